bingo_pf_scheduler: RTL and testbench
=====================================

# bingo_pf_scheduler

Request scheduler between the upper-level cache, the Bingo prefetcher and the lower-level cache. Demand misses and prefetch candidates share the single lower-level request port. The block queues block-aligned prefetch addresses and drops duplicates. It squashes queued prefetches that a demand miss covers, and arbitrates the port with demand priority plus a starvation guard.

## Interface
- WIDTH, 64, address width
- QUEUE_DEPTH, 8, prefetch queue entries (power of two, ≥2)
- BLOCK_OFFSET, 6, log2 cache block bytes; low bits cleared on every address
- STARVE_LIMIT, 4, consecutive demand grants tolerated while queue non-empty
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- up_address_i  in  WIDTH  demand miss address
- up_valid_i  in  1  demand access valid
- up_miss_i  in  1  demand access missed; request = up_valid_i & up_miss_i, held until up_ready_o
- up_ready_o  out  1  demand request accepted this cycle
- pf_address_i  in  WIDTH  prefetch candidate from prefetcher
- pf_valid_i  in  1  candidate valid, held until pf_ready_o
- pf_ready_o  out  1  candidate accepted (enqueued or dropped) this cycle
- lo_ready_i  in  1  lower level accepts request
- lo_req_address_o  out  WIDTH  block-aligned request address
- lo_req_valid_o  out  1  request valid
- lo_req_prefetch_o  out  1  1 = prefetch, 0 = demand
- pf_issued_count_o  out  16  prefetches accepted by lower level, saturating
- pf_dropped_count_o  out  16  prefetches dropped or squashed, saturating

## Operation
- Block address = address with low BLOCK_OFFSET bits zeroed. All compares and outputs use block addresses.
- Queue: circular FIFO with QUEUE_DEPTH entries, each {block, valid}. Pointers are one bit wider than the index, so full and empty are distinguished. The occupancy count includes invalidated entries.
- pf_ready_o = !full. A full queue blocks a push even when a pop happens in the same cycle.
- Duplicate filter: an accepted candidate is dropped (no enqueue, drop count +1) when its block matches any of:
  - a valid queue entry;
  - the output register while lo_req_valid_o is high;
  - the demand block granted in the same cycle.
- Squash: when a demand is granted, every valid queue entry with the same block has valid cleared. Drop count +1 per squashed entry; with the duplicate filter at most one entry can match.
- Head skip: when the head entry is invalid, it is popped without issue, one per cycle. This pop does not consume a grant cycle for a valid entry.
- Output register: loads when empty or being accepted (lo_req_valid_o & lo_ready_i). Holds address, valid and prefetch flag stable while valid & !lo_ready_i.
- Arbitration, evaluated when the output register can load:
  - If the demand request is present, the head is valid and streak < STARVE_LIMIT: grant demand and increment streak.
  - If the demand request is present and streak == STARVE_LIMIT with a valid head: grant the prefetch and clear streak.
  - If only a valid head is present: grant the prefetch and clear streak.
  - If the queue is empty, a demand grant does not increment streak, and streak resets to 0.
- up_ready_o = demand granted this cycle (combinational from the registered state and inputs).
- FSM on the output stage:
  - IDLE (empty): goes to DEMAND or PREFETCH on a grant.
  - DEMAND / PREFETCH: on lo_ready_i, go to the next grant state, or to IDLE if there is no grant. Otherwise stay.
- pf_issued_count_o increments when a PREFETCH-state request is accepted. Both counters saturate at 16'hFFFF.

## Timing
- Reset (rst low, asynchronous): queue empty, all valid bits 0, streak 0, FSM IDLE.
  - lo_req_valid_o, lo_req_address_o, lo_req_prefetch_o and both counters are 0.
  - up_ready_o and pf_ready_o are forced 0 while rst is low.
  - pf_ready_o is 1 in the first cycle after deassertion.
- Reset asserted mid-transaction discards the in-flight request; no completion is reported.
- Demand granted at cycle t: lo_req_valid_o = 1 from t+1.
- Prefetch enqueued at t: it is at the head at t+1 at earliest, so the earliest lo_req_valid_o is t+2.
- Back-to-back: with lo_ready_i held high, one request per cycle.
- Squash and enqueue decisions made in the same cycle both use pre-edge queue contents, plus the same-cycle demand block.

## Test plan
- Reset, then one demand miss at 0x1234 with lo_ready_i = 1 -> up_ready_o = 1 that cycle; next cycle lo_req_address_o = 0x1200, lo_req_prefetch_o = 0; up_ready_o and pf_ready_o are 0 during reset.
- Push prefetches 0x1000, 0x1040 and 0x1010 with lo_ready_i = 0 -> two entries queued; 0x1010 dropped (pf_dropped_count_o = 1); after lo_ready_i rises, issue order is 0x1000 then 0x1040, pf_issued_count_o = 2.
- Push 9 distinct prefetches into QUEUE_DEPTH = 8 with lo_ready_i = 0 -> pf_ready_o = 0 after the 8th push; the 9th is held until a pop frees an entry; no entry is lost or duplicated.
- Queue 0x2000 and 0x3000, then demand miss at 0x2008 -> demand 0x2000 issued; queued 0x2000 squashed (drop count +1) and skipped; 0x3000 issued next.
- Demand miss held continuously with the queue non-empty, lo_ready_i = 1 -> grant pattern of 4 demand, 1 prefetch, repeating.
- Assert rst while lo_req_valid_o = 1 and lo_ready_i = 0 -> all outputs 0 immediately, without waiting for a clock edge; the queue is empty after release.

Source files
------------

// File: rtl/bingo_pf_scheduler_if.sv
// bingo_pf_scheduler_if: demand, prefetch and lower-level request signals of the scheduler.
interface bingo_pf_scheduler_if #(parameter int WIDTH = 64);
  logic [WIDTH-1:0] up_address;
  logic             up_valid;
  logic             up_miss;
  logic             up_ready;
  logic [WIDTH-1:0] pf_address;
  logic             pf_valid;
  logic             pf_ready;
  logic             lo_ready;
  logic [WIDTH-1:0] lo_req_address;
  logic             lo_req_valid;
  logic             lo_req_prefetch;
  logic [15:0]      pf_issued_count;
  logic [15:0]      pf_dropped_count;
  modport master (
    output up_address, up_valid, up_miss, pf_address, pf_valid, lo_ready,
    input  up_ready, pf_ready, lo_req_address, lo_req_valid, lo_req_prefetch,
           pf_issued_count, pf_dropped_count
  );
  modport slave (
    input  up_address, up_valid, up_miss, pf_address, pf_valid, lo_ready,
    output up_ready, pf_ready, lo_req_address, lo_req_valid, lo_req_prefetch,
           pf_issued_count, pf_dropped_count
  );
endinterface

// File: rtl/bingo_pf_scheduler.sv
// bingo_pf_scheduler: shares the lower-level port between demand misses and queued Bingo prefetches,
// with duplicate filtering, demand squash of queued prefetches and a starvation guard.
module bingo_pf_scheduler #(
  parameter int WIDTH        = 64,
  parameter int QUEUE_DEPTH  = 8,
  parameter int BLOCK_OFFSET = 6,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  bingo_pf_scheduler_if.slave bus
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WIDTH-1:0] MASK = ~((WIDTH'(1) << BLOCK_OFFSET) - WIDTH'(1));
  localparam logic [1:0] IDLE = 2'd0, DEMAND = 2'd1, PREFETCH = 2'd2;
  logic [WIDTH-1:0] q_blk [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] q_vld, q_hit, sq_hit, enq_mask, pop_mask;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [SW-1:0] streak;
  logic [1:0] state;
  logic [WIDTH-1:0] out_addr, dem_blk, pf_blk;
  logic [15:0] issued, dropped;
  logic [16:0] drop_sum;
  logic [1:0] drop_inc;
  logic full, empty, out_valid, can_load, dem_req, head_valid, head_skip;
  logic grant_dem, grant_pf, push, dup, enq, pop;
  assign wr_idx     = wr_ptr[AW-1:0];
  assign rd_idx     = rd_ptr[AW-1:0];
  assign dem_blk    = bus.up_address & MASK;
  assign pf_blk     = bus.pf_address & MASK;
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign empty      = wr_ptr == rd_ptr;
  assign out_valid  = state != IDLE;
  assign can_load   = !out_valid || bus.lo_ready;
  assign dem_req    = bus.up_valid && bus.up_miss;
  assign head_valid = !empty && q_vld[rd_idx];
  assign head_skip  = !empty && !q_vld[rd_idx];
  assign grant_dem  = can_load && dem_req && (!head_valid || streak < SW'(STARVE_LIMIT));
  assign grant_pf   = can_load && head_valid && (!dem_req || streak == SW'(STARVE_LIMIT));
  assign pop        = grant_pf || head_skip;
  assign push       = bus.pf_valid && bus.pf_ready;
  always_comb begin
    q_hit  = '0;
    sq_hit = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      q_hit[i]  = q_vld[i] && q_blk[i] == pf_blk;
      sq_hit[i] = grant_dem && q_vld[i] && q_blk[i] == dem_blk;
    end
  end
  // Filter sees pre-edge queue and output register, plus the demand granted this very cycle.
  assign dup      = |q_hit || (out_valid && out_addr == pf_blk) || (grant_dem && dem_blk == pf_blk);
  assign enq      = push && !dup;
  assign enq_mask = enq ? QUEUE_DEPTH'(1) << wr_idx : '0;
  assign pop_mask = pop ? QUEUE_DEPTH'(1) << rd_idx : '0;
  assign drop_inc = {1'b0, push && dup} + {1'b0, |sq_hit};
  assign drop_sum = {1'b0, dropped} + 17'(drop_inc);
  always_ff @(posedge clk)
    if (enq) q_blk[wr_idx] <= pf_blk;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_vld    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      streak   <= '0;
      state    <= IDLE;
      out_addr <= '0;
      issued   <= '0;
      dropped  <= '0;
    end else begin
      q_vld  <= (q_vld & ~sq_hit & ~pop_mask) | enq_mask;
      wr_ptr <= wr_ptr + (AW+1)'(enq);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      streak <= (grant_pf || !head_valid) ? '0 : grant_dem ? streak + SW'(1) : streak;
      if (can_load) begin
        state    <= grant_dem ? DEMAND : grant_pf ? PREFETCH : IDLE;
        out_addr <= grant_dem ? dem_blk : grant_pf ? q_blk[rd_idx] : out_addr;
      end
      if (state == PREFETCH && bus.lo_ready && issued != 16'hFFFF) issued <= issued + 16'd1;
      dropped <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
  assign bus.up_ready         = rst && grant_dem;
  assign bus.pf_ready         = rst && !full;
  assign bus.lo_req_valid     = out_valid;
  assign bus.lo_req_prefetch  = state == PREFETCH;
  assign bus.lo_req_address   = out_addr;
  assign bus.pf_issued_count  = issued;
  assign bus.pf_dropped_count = dropped;
endmodule

// File: tb/tb_bingo_pf_scheduler.sv
// tb_bingo_pf_scheduler: scoreboard bench; expected lower-level requests are queued as stimulus is driven.
module tb_bingo_pf_scheduler;
  localparam logic [63:0] MASK = ~64'h3F;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [64:0] exp_q [$];
  int checks = 0;
  int failures = 0;
  bingo_pf_scheduler_if #(.WIDTH(64)) bus ();
  bingo_pf_scheduler #(.WIDTH(64), .QUEUE_DEPTH(8), .BLOCK_OFFSET(6), .STARVE_LIMIT(4))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (rst && bus.lo_req_valid && bus.lo_ready) begin
      if (exp_q.size() == 0) check("issue_unexpected", {bus.lo_req_prefetch, bus.lo_req_address}, '1);
      else check("issue", {bus.lo_req_prefetch, bus.lo_req_address}, exp_q.pop_front());
    end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic dem(input logic [63:0] a);
    bus.up_address = a;
    bus.up_valid   = 1'b1;
    bus.up_miss    = 1'b1;
    exp_q.push_back({1'b0, a & MASK});
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.up_ready) break;
    end
    check("dem_grant", bus.up_ready, 1);
    @(posedge clk);
    #1;
    bus.up_valid = 1'b0;
    bus.up_miss  = 1'b0;
  endtask
  task automatic pf(input logic [63:0] a, input logic issue);
    bus.pf_address = a;
    bus.pf_valid   = 1'b1;
    if (issue) exp_q.push_back({1'b1, a & MASK});
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.pf_ready) break;
    end
    check("pf_accept", bus.pf_ready, 1);
    @(posedge clk);
    #1;
    bus.pf_valid = 1'b0;
  endtask
  initial begin
    int n;
    bus.up_address = 64'h0; bus.up_valid = 1'b1; bus.up_miss = 1'b1;
    bus.pf_address = 64'h0; bus.pf_valid = 1'b1; bus.lo_ready = 1'b1;
    #12;
    check("rst_up_ready", bus.up_ready, 0);
    check("rst_pf_ready", bus.pf_ready, 0);
    check("rst_valid", bus.lo_req_valid, 0);
    check("rst_addr", bus.lo_req_address, 0);
    check("rst_counts", {bus.pf_issued_count, bus.pf_dropped_count}, 0);
    bus.up_valid = 1'b0; bus.up_miss = 1'b0; bus.pf_valid = 1'b0;
    #10 rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_pf_ready", bus.pf_ready, 1);
    dem(64'h1234);
    check("dem_addr", bus.lo_req_address, 64'h1200);
    check("dem_kind", {bus.lo_req_valid, bus.lo_req_prefetch}, 2'b10);
    cyc(2);
    bus.lo_ready = 1'b0;
    pf(64'h1000, 1'b1);
    pf(64'h1040, 1'b1);
    pf(64'h1010, 1'b0);
    check("dup_drop", bus.pf_dropped_count, 1);
    bus.lo_ready = 1'b1;
    cyc(5);
    check("issued_2", bus.pf_issued_count, 2);
    bus.lo_ready = 1'b0;
    dem(64'hA000);
    for (int i = 0; i < 8; i++) pf(64'h4000 + 64'(i) * 64'h40, 1'b1);
    check("full", bus.pf_ready, 0);
    bus.pf_address = 64'h4200;
    bus.pf_valid   = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("full_hold", bus.pf_ready, 0);
    end
    @(posedge clk); #1;
    bus.lo_ready = 1'b1;
    pf(64'h4200, 1'b1);
    cyc(14);
    check("issued_11", bus.pf_issued_count, 11);
    check("drop_still_1", bus.pf_dropped_count, 1);
    bus.lo_ready = 1'b0;
    dem(64'hB000);
    pf(64'h2000, 1'b0);
    pf(64'h3000, 1'b0);
    bus.lo_ready = 1'b1;
    dem(64'h2008);
    exp_q.push_back({1'b1, 64'h3000});
    cyc(5);
    check("squash_drop", bus.pf_dropped_count, 2);
    check("issued_12", bus.pf_issued_count, 12);
    bus.lo_ready = 1'b0;
    dem(64'hC000);
    pf(64'h5000, 1'b0);
    pf(64'h5040, 1'b0);
    pf(64'h5080, 1'b0);
    for (int p = 0; p < 3; p++) begin
      repeat (4) exp_q.push_back({1'b0, 64'h6000});
      exp_q.push_back({1'b1, 64'h5000 + 64'(p) * 64'h40});
    end
    bus.up_address = 64'h6000; bus.up_valid = 1'b1; bus.up_miss = 1'b1;
    bus.lo_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && n < 12; i++) begin
      @(negedge clk);
      if (bus.up_ready) n++;
    end
    check("starve_grants", n, 12);
    @(posedge clk); #1;
    bus.up_valid = 1'b0; bus.up_miss = 1'b0;
    cyc(6);
    check("issued_15", bus.pf_issued_count, 15);
    bus.lo_ready = 1'b0;
    dem(64'hD000);
    pf(64'h7000, 1'b0);
    bus.up_address = 64'hE000; bus.up_valid = 1'b1; bus.up_miss = 1'b1;
    #3 rst = 1'b0;
    #1;
    check("mid_rst_valid", bus.lo_req_valid, 0);
    check("mid_rst_addr", {bus.lo_req_prefetch, bus.lo_req_address}, 0);
    check("mid_rst_counts", {bus.pf_issued_count, bus.pf_dropped_count}, 0);
    check("mid_rst_ready", {bus.up_ready, bus.pf_ready}, 0);
    exp_q.delete();
    bus.up_valid = 1'b0; bus.up_miss = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_pf_ready", bus.pf_ready, 1);
    bus.lo_ready = 1'b1;
    cyc(4);
    check("rel_queue_empty", bus.lo_req_valid, 0);
    check("rel_issued", bus.pf_issued_count, 0);
    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
